cpu_dbg_ctrl: RTL and testbench
===============================

Name: cpu_dbg_ctrl

Overview:
Run-control and debug sequencer for the single-cycle MIPS core.
- Generates a clock-enable `cpu_ce` that the core's PC and register-file write path must qualify with. The core commits one instruction per cycle in which `cpu_ce`=1.
- Provides run, halt, N-step and one hardware PC breakpoint.
- Provides a handshaked register-file dump that walks the core's debug register-select port (`reg_sel`/`reg_data`).
- Sits between the board/host debug interface and the core.

Parameters:
- CNT_W, 32, width of the committed-instruction counter `icount`.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- run_req  in  1  level-sampled request: free-run the core
- halt_req  in  1  request: stop the core; highest priority
- step_req  in  1  request: execute `step_n` instructions, then halt
- step_n  in  8  step count; 0 is treated as 1
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC
- pc  in  32  current PC from the core
- cpu_ce  out  1  core commit enable
- dbg_sel  in  5  host register select, used outside dump
- reg_sel  out  5  register select driven to the core
- reg_data  in  32  selected register value from the core
- dump_req  in  1  start register dump
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  dump beat accepted
- dump_idx  out  5  register index of the current beat
- dump_data  out  32  register value of the current beat
- state  out  3  HALT=0, RUN=1, STEP=2, BRK=3, DUMP=4
- icount  out  CNT_W  count of cycles with `cpu_ce`=1

Behaviour:
- Reset (async, any state, including mid-step and mid-dump):
  - state=HALT, `cpu_ce`=0, `dump_valid`=0, `dump_idx`=0, `icount`=0, step counter=0, `skip_bp`=0.
- `cpu_ce` is combinational: `cpu_ce` = (RUN & !halt_req & !(bp_hit & !skip_bp)) | (STEP & !halt_req).
  - bp_hit = bp_en & (pc == bp_addr).
  - The instruction at a breakpoint is not committed.
- HALT:
  - halt_req → stay in HALT.
  - else step_req → STEP, with step counter = max(step_n, 1).
  - else run_req → RUN, `skip_bp`=1.
  - else dump_req → DUMP, return target = HALT.
- RUN:
  - halt_req → HALT; no commit that cycle.
  - bp_hit & !skip_bp → BRK; no commit that cycle.
  - otherwise commit one instruction.
  - `skip_bp` clears after the first cycle in which `cpu_ce`=1. This lets a resume from a breakpoint execute the breakpoint instruction once.
- STEP:
  - Commits every cycle; breakpoints are ignored.
  - Counter decrements per commit. When the commit happens with counter=1, next state is HALT.
  - halt_req aborts: no commit, next state HALT.
- BRK:
  - Same transitions as HALT.
  - A run_req resume sets `skip_bp`=1.
  - dump_req return target = BRK.
- DUMP:
  - `reg_sel` = `dump_idx`; `dump_data` = `reg_data` (combinational pass-through); `dump_valid`=1.
  - `dump_idx` increments on dump_valid & dump_ready.
  - Acceptance at idx 31 → return to the saved HALT/BRK state, `dump_valid`=0, `dump_idx` reset to 0.
  - run, step, halt and dump requests are ignored while in DUMP.
  - `cpu_ce`=0 throughout.
- Outside DUMP: `reg_sel` = `dbg_sel`, `dump_valid`=0.
- `dump_data` and `dump_idx` must be held stable while dump_valid & !dump_ready.
- `icount` increments on every cycle with `cpu_ce`=1 and wraps modulo 2^CNT_W.
- Simultaneous requests resolve by priority: halt > step > run > dump.

Test Plan:
- Reset, then run_req for 10 cycles → `cpu_ce`=1 each cycle, `icount`=10, state=RUN; assert halt_req → `cpu_ce`=0 in that same cycle, state=HALT next cycle.
- bp_en=1, bp_addr=0x0000300C, pc sequence 0x3000, 0x3004, ... from RUN → `cpu_ce` drops when pc=0x300C, state=BRK, `icount`=3; run_req → commits at 0x300C, continues RUN.
- From HALT, step_req with step_n=3 → exactly 3 `cpu_ce` pulses, then HALT, `icount`+3; repeat with step_n=0 → exactly 1 pulse.
- Dump from BRK with dump_ready toggling every other cycle → 32 beats, idx 0..31 in order, `dump_data` matches the modelled register file, data stable during stalls, returns to BRK.
- Assert rst mid-dump at idx 17 and mid-step with 2 steps remaining → immediate HALT, `dump_valid`=0, `icount`=0.
- halt_req, step_req and run_req asserted in the same cycle in HALT → stays HALT; step_req and run_req together → STEP.

Source files
------------

// File: rtl/cpu_dbg_ctrl.sv
// ============================================================================
// Module   : cpu_dbg_ctrl
// Brief    : Run/halt/step/breakpoint sequencer and register-dump engine for
//            the single-cycle MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpu_dbg_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic [7:0]       step_n,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_ce,
  input  logic [4:0]       dbg_sel,
  output logic [4:0]       reg_sel,
  input  logic [31:0]      reg_data,
  input  logic             dump_req,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] icount
);

  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_RUN  = 3'd1,
    S_STEP = 3'd2,
    S_BRK  = 3'd3,
    S_DUMP = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state,    w_state_nxt;
  logic [7:0]       r_step_cnt, w_step_cnt_nxt;
  logic             r_skip_bp,  w_skip_bp_nxt;
  logic             r_ret_brk,  w_ret_brk_nxt;
  logic [4:0]       r_dump_idx, w_dump_idx_nxt;
  logic [CNT_W-1:0] r_icount;
  logic             w_bp_hit;
  logic             w_ce;
  logic             w_in_dump;

  always_comb begin
    w_in_dump = (r_state == S_DUMP);
    w_bp_hit  = bp_en && (pc == bp_addr);
    w_ce      = ((r_state == S_RUN) && !halt_req && !(w_bp_hit && !r_skip_bp)) ||
                ((r_state == S_STEP) && !halt_req);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_step_cnt_nxt = r_step_cnt;
    w_skip_bp_nxt  = r_skip_bp;
    w_ret_brk_nxt  = r_ret_brk;
    w_dump_idx_nxt = r_dump_idx;

    // The resumed breakpoint instruction is allowed through exactly once.
    if (w_ce) begin
      w_skip_bp_nxt = 1'b0;
    end

    case (r_state)
      S_HALT, S_BRK: begin
        if (halt_req) begin
          w_state_nxt = r_state;
        end else if (step_req) begin
          w_state_nxt    = S_STEP;
          w_step_cnt_nxt = (step_n == 8'd0) ? 8'd1 : step_n;
        end else if (run_req) begin
          w_state_nxt   = S_RUN;
          w_skip_bp_nxt = 1'b1;
        end else if (dump_req) begin
          w_state_nxt   = S_DUMP;
          w_ret_brk_nxt = (r_state == S_BRK);
        end
      end
      S_RUN: begin
        if (halt_req) begin
          w_state_nxt = S_HALT;
        end else if (w_bp_hit && !r_skip_bp) begin
          w_state_nxt = S_BRK;
        end
      end
      S_STEP: begin
        if (halt_req) begin
          w_state_nxt    = S_HALT;
          w_step_cnt_nxt = 8'd0;
        end else begin
          w_step_cnt_nxt = r_step_cnt - 8'd1;
          if (r_step_cnt <= 8'd1) begin
            w_state_nxt = S_HALT;
          end
        end
      end
      S_DUMP: begin
        // Index wraps 31 -> 0 on the final beat, ready for the next dump.
        if (dump_ready) begin
          w_dump_idx_nxt = r_dump_idx + 5'd1;
          if (r_dump_idx == 5'd31) begin
            w_state_nxt = r_ret_brk ? S_BRK : S_HALT;
          end
        end
      end
      default: begin
        w_state_nxt = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_HALT;
      r_step_cnt <= 8'd0;
      r_skip_bp  <= 1'b0;
      r_ret_brk  <= 1'b0;
      r_dump_idx <= 5'd0;
      r_icount   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_skip_bp  <= w_skip_bp_nxt;
      r_ret_brk  <= w_ret_brk_nxt;
      r_dump_idx <= w_dump_idx_nxt;
      if (w_ce) begin
        r_icount <= r_icount + C_CNT_ONE;
      end
    end
  end

  assign cpu_ce     = w_ce;
  assign dump_valid = w_in_dump;
  assign reg_sel    = w_in_dump ? r_dump_idx : dbg_sel;
  assign dump_idx   = r_dump_idx;
  assign dump_data  = reg_data;
  assign state      = r_state;
  assign icount     = r_icount;

endmodule

`default_nettype wire

// File: tb/tb_cpu_dbg_ctrl.sv
// ============================================================================
// Module   : tb_cpu_dbg_ctrl
// Brief    : Self-checking bench for cpu_dbg_ctrl (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_dbg_ctrl;

  localparam int CNT_W = 32;
  localparam logic [2:0] C_HALT = 3'd0;
  localparam logic [2:0] C_RUN  = 3'd1;
  localparam logic [2:0] C_STEP = 3'd2;
  localparam logic [2:0] C_BRK  = 3'd3;
  localparam logic [2:0] C_DUMP = 3'd4;

  logic             clk = 1'b0;
  logic             rst;
  logic             run_req, halt_req, step_req, dump_req, dump_ready, bp_en;
  logic [7:0]       step_n;
  logic [31:0]      bp_addr, pc, reg_data, dump_data;
  logic             cpu_ce, dump_valid;
  logic [4:0]       dbg_sel, reg_sel, dump_idx;
  logic [2:0]       state;
  logic [CNT_W-1:0] icount;

  logic             pc_load;
  logic [31:0]      pc_init;
  logic [31:0]      regs [32];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        run, halt, step, dump;
    logic [7:0]  sn;
    logic        ce;
    logic [2:0]  st;
    logic [31:0] ic;
  } vec_t;

  typedef struct {
    logic        ce;
    logic [2:0]  st;
    logic [31:0] ic;
  } exp_t;

  vec_t       tbl[$];
  exp_t       exp_q[$];
  logic [4:0] idx_q[$];

  cpu_dbg_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .step_n     (step_n),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .cpu_ce     (cpu_ce),
    .dbg_sel    (dbg_sel),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .state      (state),
    .icount     (icount)
  );

  always #5 clk = ~clk;

  // Minimal core model: PC advances by one instruction per commit.
  always @(posedge clk) begin
    if (pc_load) pc <= pc_init;
    else if (cpu_ce) pc <= pc + 32'd4;
  end

  assign reg_data = regs[reg_sel];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic vec_t mk(input logic run, input logic halt, input logic step,
                              input logic dump, input logic [7:0] sn, input logic ce,
                              input logic [2:0] st, input logic [31:0] ic);
    vec_t v;
    v.run = run; v.halt = halt; v.step = step; v.dump = dump; v.sn = sn;
    v.ce = ce; v.st = st; v.ic = ic;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    logic ce_seen;
    @(negedge clk);
    run_req = v.run; halt_req = v.halt; step_req = v.step;
    dump_req = v.dump; step_n = v.sn;
    exp_q.push_back('{ce: v.ce, st: v.st, ic: v.ic});
    #2 ce_seen = cpu_ce;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk1("cpu_ce", ce_seen, e.ce);
    chk("state", {29'd0, state}, {29'd0, e.st});
    chk("icount", icount, e.ic);
  endtask

  // Drives dump_ready and scores each accepted beat against the register model.
  task automatic dump_beats(input int n_beats, input bit toggle);
    int         got = 0;
    int         cyc = 0;
    bit         rdy;
    bit         stalled = 1'b0;
    logic [4:0] exp_idx;
    logic [4:0] last_idx = 5'd0;
    logic [31:0] last_data = 32'd0;
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; dump_req = 1'b0;
    for (int k = 0; k < 32; k++) idx_q.push_back(k[4:0]);
    while (got < n_beats && cyc < 200) begin
      @(negedge clk);
      rdy = toggle ? cyc[0] : 1'b1;
      dump_ready = rdy;
      cyc++;
      #2;
      chk1("dump_valid", dump_valid, 1'b1);
      chk1("dump_cpu_ce", cpu_ce, 1'b0);
      if (stalled) begin
        chk("hold_idx", {27'd0, dump_idx}, {27'd0, last_idx});
        chk("hold_data", dump_data, last_data);
      end
      if (rdy) begin
        exp_idx = idx_q.pop_front();
        chk("beat_idx", {27'd0, dump_idx}, {27'd0, exp_idx});
        chk("beat_data", dump_data, regs[exp_idx]);
        got++;
      end
      stalled   = !rdy;
      last_idx  = dump_idx;
      last_data = dump_data;
    end
    if (got < n_beats) chk("dump_timeout_beats", got, n_beats);
    idx_q.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; dump_req = 1'b0;
    step_n = 8'd0; dump_ready = 1'b0; bp_en = 1'b0; bp_addr = 32'd0; dbg_sel = 5'd0;
    pc_load = 1'b1; pc_init = 32'h0000_1000;
    for (int r = 0; r < 32; r++) regs[r] = $urandom();

    // Run / halt / step / priority table
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, C_RUN, 32'd0));
    for (int i = 1; i <= 10; i++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_RUN, 32'(i)));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, C_HALT, 32'd10));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b0, C_HALT, 32'd10));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0, C_STEP, 32'd10));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_STEP, 32'd11));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_HALT, 32'd12));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, C_HALT, 32'd12));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 1'b0, C_STEP, 32'd12));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_STEP, 32'd13));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_STEP, 32'd14));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_HALT, 32'd15));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, C_HALT, 32'd15));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, C_STEP, 32'd15));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_HALT, 32'd16));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, C_HALT, 32'd16));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd5, 1'b0, C_STEP, 32'd16));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_STEP, 32'd17));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, C_HALT, 32'd17));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, C_HALT, 32'd17));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, C_RUN, 32'd17));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, C_HALT, 32'd17));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", {29'd0, state}, {29'd0, C_HALT});
    chk1("rst_cpu_ce", cpu_ce, 1'b0);
    chk1("rst_dump_valid", dump_valid, 1'b0);
    chk("rst_dump_idx", {27'd0, dump_idx}, 32'd0);
    chk("rst_icount", icount, 32'd0);
    @(negedge clk);
    rst = 1'b0; pc_load = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Outside a dump the host select reaches the core
    @(negedge clk);
    dbg_sel = 5'd7;
    #1;
    chk("reg_sel_host", {27'd0, reg_sel}, 32'd7);
    chk("dump_data_pass", dump_data, regs[7]);

    // Breakpoint: reset, load PC 0x3000, break at 0x300C
    @(negedge clk);
    rst = 1'b1; pc_load = 1'b1; pc_init = 32'h0000_3000;
    bp_en = 1'b1; bp_addr = 32'h0000_300C;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; pc_load = 1'b0;
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, C_RUN, 32'd0));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_RUN, 32'd1));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_RUN, 32'd2));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_RUN, 32'd3));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, C_BRK, 32'd3));
    chk("bp_pc", pc, 32'h0000_300C);

    // Full dump from BRK with a stalling consumer
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, C_DUMP, 32'd3));
    dump_beats(32, 1'b1);
    @(posedge clk);
    #1;
    chk("dump_ret_state", {29'd0, state}, {29'd0, C_BRK});
    chk1("dump_end_valid", dump_valid, 1'b0);
    chk("dump_end_idx", {27'd0, dump_idx}, 32'd0);
    @(negedge clk);
    dump_ready = 1'b0;

    // Resume commits the breakpoint instruction once
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, C_RUN, 32'd3));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_RUN, 32'd4));
    apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_RUN, 32'd5));
    apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, C_HALT, 32'd5));

    // Reset in the middle of a dump at index 17
    apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, C_DUMP, 32'd5));
    dump_beats(17, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_dump_idx", {27'd0, dump_idx}, 32'd17);
    dump_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rstdump_state", {29'd0, state}, {29'd0, C_HALT});
    chk1("rstdump_valid", dump_valid, 1'b0);
    chk("rstdump_idx", {27'd0, dump_idx}, 32'd0);
    chk("rstdump_icount", icount, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a step with two steps still to go
    apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 1'b0, C_STEP, 32'd0));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_STEP, 32'd1));
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, C_STEP, 32'd2));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rststep_state", {29'd0, state}, {29'd0, C_HALT});
    chk1("rststep_cpu_ce", cpu_ce, 1'b0);
    chk("rststep_icount", icount, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, C_HALT, 32'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
